// File: rtl/rinsc_pkg.sv
// Shared definitions for the RINSC decode stage: opcodes, control field
// encodings, the control bundle and the in-flight destination entry.
package rinsc_pkg;

    // Opcode map
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_R_LO  = 8'h01;
    localparam logic [7:0] OP_R_HI  = 8'h09;
    localparam logic [7:0] OP_I_LO  = 8'h11;
    localparam logic [7:0] OP_I_HI  = 8'h19;
    localparam logic [7:0] OP_SH_LO = 8'h26;
    localparam logic [7:0] OP_SH_HI = 8'h28;
    localparam logic [7:0] OP_LW    = 8'h30;
    localparam logic [7:0] OP_SW    = 8'h31;
    localparam logic [7:0] OP_JMP   = 8'h40;
    localparam logic [7:0] OP_JAL   = 8'h41;

    // ALU operation base values subtracted from the opcode low nibble
    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] R_BASE_LO   = 4'h1;
    localparam logic [3:0] I_BASE_LO   = 4'h1;
    localparam logic [3:0] SH_BASE_LO  = 4'h0;

    // ALU B-operand select
    localparam logic [1:0] SRC_REG   = 2'b00;
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_SHAMT = 2'b10;

    // Writeback select
    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // One scoreboard slot per instruction in EX, MEM and WB
    localparam int PEND_DEPTH = 3;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } pend_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       pc_src;
        logic [1:0] mem_to_reg;
        logic [3:0] alu_op;
        logic [1:0] alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'(12'd0);

    // Event counters stick at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode decoder: produces the control bundle, which
// source registers the instruction reads, and an undefined-opcode flag.
module control_decoder
    import rinsc_pkg::*;
(
    input  logic [7:0] op,
    output ctrl_t      ctrl,
    output logic       uses_rs1,
    output logic       uses_rs2,
    output logic       illegal
);

    // Opcode to control bundle; unknown opcodes fall back to a NOP
    always_comb begin
        ctrl     = CTRL_NONE;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        illegal  = 1'b0;
        if (op == OP_NOP) begin
            ctrl = CTRL_NONE;
        end else if ((op >= OP_R_LO) && (op <= OP_R_HI)) begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_ALU;
            ctrl.alu_src    = SRC_REG;
            ctrl.alu_op     = op[3:0] - R_BASE_LO;
            uses_rs1        = 1'b1;
            uses_rs2        = 1'b1;
        end else if ((op >= OP_I_LO) && (op <= OP_I_HI)) begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_ALU;
            ctrl.alu_src    = SRC_IMM;
            ctrl.alu_op     = op[3:0] - I_BASE_LO;
            uses_rs1        = 1'b1;
        end else if ((op >= OP_SH_LO) && (op <= OP_SH_HI)) begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_ALU;
            ctrl.alu_src    = SRC_SHAMT;
            ctrl.alu_op     = op[3:0] - SH_BASE_LO;
            uses_rs1        = 1'b1;
        end else if (op == OP_LW) begin
            ctrl.mem_read   = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_MEM;
            ctrl.alu_src    = SRC_IMM;
            ctrl.alu_op     = ALU_ADD;
            uses_rs1        = 1'b1;
        end else if (op == OP_SW) begin
            ctrl.mem_write  = 1'b1;
            ctrl.alu_src    = SRC_IMM;
            ctrl.alu_op     = ALU_ADD;
            uses_rs1        = 1'b1;
            uses_rs2        = 1'b1;
        end else if (op == OP_JMP) begin
            ctrl.pc_src     = 1'b1;
        end else if (op == OP_JAL) begin
            ctrl.pc_src     = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = WB_PC4;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// ID-stage pipeline control: decodes the IF/ID instruction, detects RAW
// hazards against the three older in-flight writers, inserts bubbles,
// flushes after jumps and keeps sticky/saturating status.
module pipeline_control
    import rinsc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  Op,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    input  logic [4:0]  Rd,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        PCSrc,
    output logic [1:0]  MemToReg,
    output logic [3:0]  ALUOp,
    output logic [1:0]  ALUSrc,
    output logic        Stall,
    output logic        Flush,
    output logic        Illegal,
    output logic [15:0] StallCount,
    output logic [15:0] FlushCount
);

    ctrl_t       dec_ctrl_s;
    ctrl_t       ctrl_s;
    logic        uses_rs1_s;
    logic        uses_rs2_s;
    logic        dec_illegal_s;
    logic        active_s;
    logic        hazard_s;
    logic        stall_s;
    logic        issue_s;
    logic        flush_s;

    logic        id_valid_r;
    pend_t       pend_r [PEND_DEPTH];
    logic        illegal_r;
    logic [15:0] stall_count_r;
    logic [15:0] flush_count_r;

    control_decoder u_decoder (
        .op       (Op),
        .ctrl     (dec_ctrl_s),
        .uses_rs1 (uses_rs1_s),
        .uses_rs2 (uses_rs2_s),
        .illegal  (dec_illegal_s)
    );

    // Gating reset here forces every control output low while reset is held
    assign active_s = id_valid_r & ~reset;

    // RAW hazard: any used source matches a valid in-flight destination (r0 included)
    always_comb begin
        hazard_s = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            hazard_s = hazard_s | (pend_r[i].valid &
                       ((uses_rs1_s & (pend_r[i].rd == Rs1)) |
                        (uses_rs2_s & (pend_r[i].rd == Rs2))));
        end
    end

    // Issue or bubble; jumps never stall because they read no sources
    always_comb begin
        stall_s = active_s & hazard_s;
        issue_s = active_s & ~hazard_s;
        if (issue_s) begin
            ctrl_s = dec_ctrl_s;
        end else begin
            ctrl_s = CTRL_NONE;
        end
        flush_s = issue_s & dec_ctrl_s.pc_src;
    end

    assign MemRead    = ctrl_s.mem_read;
    assign MemWrite   = ctrl_s.mem_write;
    assign RegWrite   = ctrl_s.reg_write;
    assign PCSrc      = ctrl_s.pc_src;
    assign MemToReg   = ctrl_s.mem_to_reg;
    assign ALUOp      = ctrl_s.alu_op;
    assign ALUSrc     = ctrl_s.alu_src;
    assign Stall      = stall_s;
    assign Flush      = flush_s;
    assign Illegal    = illegal_r;
    assign StallCount = stall_count_r;
    assign FlushCount = flush_count_r;

    // IF/ID valid bit: held while stalled, dropped for the slot behind a jump
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_valid_r <= 1'b0;
        end else if (!stall_s) begin
            id_valid_r <= ~flush_s;
        end else begin
            id_valid_r <= id_valid_r;
        end
    end

    // Destination scoreboard shifts every edge; bubbles enter as invalid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                pend_r[i] <= pend_t'(6'd0);
            end
        end else begin
            pend_r[0].valid <= ctrl_s.reg_write;
            pend_r[0].rd    <= Rd;
            for (int i = 1; i < PEND_DEPTH; i++) begin
                pend_r[i] <= pend_r[i-1];
            end
        end
    end

    // Sticky undefined-opcode flag, cleared only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if (active_s && dec_illegal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Saturating stall and flush event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_r <= 16'd0;
            flush_count_r <= 16'd0;
        end else begin
            stall_count_r <= stall_s ? sat_inc16(stall_count_r) : stall_count_r;
            flush_count_r <= flush_s ? sat_inc16(flush_count_r) : flush_count_r;
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench for pipeline_control: the driver pushes hand-computed
// expected outputs per cycle, an independent monitor pops and compares.
module tb_pipeline_control;

    logic        clk;
    logic        reset;
    logic [7:0]  Op;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        PCSrc;
    logic [1:0]  MemToReg;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrc;
    logic        Stall;
    logic        Flush;
    logic        Illegal;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    typedef struct {
        string       name;
        logic [46:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp;
    int          n_bad;
    logic [46:0] act;

    pipeline_control dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Rs1        (Rs1),
        .Rs2        (Rs2),
        .Rd         (Rd),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .PCSrc      (PCSrc),
        .MemToReg   (MemToReg),
        .ALUOp      (ALUOp),
        .ALUSrc     (ALUSrc),
        .Stall      (Stall),
        .Flush      (Flush),
        .Illegal    (Illegal),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    assign act = {MemRead, MemWrite, RegWrite, PCSrc, MemToReg, ALUOp, ALUSrc,
                  Stall, Flush, Illegal, StallCount, FlushCount};

    initial clk = 1'b0;
    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Monitor: compare the DUT outputs of each expected cycle on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp = n_cmp + 1;
            if (act !== e.v) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got %h expected %h (ctl4 m2r alu src stall flush illegal sc fc)",
                         e.name, act, e.v);
            end
        end
    end

    // Watchdog: the run must finish within a bounded time
    initial begin
        #2000000;
        n_bad = n_bad + 1;
        $display("FAIL timeout: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $finish;
    end

    // Immediate comparison of the current DUT outputs
    task automatic check_now(input string nm, input logic [46:0] expv);
        n_cmp = n_cmp + 1;
        if (act !== expv) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Apply one instruction cycle and queue the outputs expected in that cycle
    task automatic cyc(input string nm, input logic r, input logic [7:0] op,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic [3:0] ctl, input logic [1:0] m2r, input logic [3:0] alu,
                       input logic [1:0] src, input logic [2:0] sfi,
                       input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r;
        Op    = op;
        Rs1   = s1;
        Rs2   = s2;
        Rd    = d;
        e.name = nm;
        e.v    = {ctl, m2r, alu, src, sfi, sc, fc};
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        cyc("rst_hold", 1'b1, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        #1;
        check_now("rst_state", 47'd0);
        cyc("rst_rel",  1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        Op    = 8'h00;
        Rs1   = 5'd0;
        Rs2   = 5'd0;
        Rd    = 5'd0;

        // Back-to-back RAW: 3 stall cycles, issue on the 4th
        do_reset();
        cyc("raw_prod",   1'b0, 8'h01, 5'd2, 5'd3, 5'd1, 4'b0010, 2'b01, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("raw_stall1", 1'b0, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b100, 16'd0, 16'd0);
        cyc("raw_stall2", 1'b0, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b100, 16'd1, 16'd0);
        cyc("raw_stall3", 1'b0, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b100, 16'd2, 16'd0);
        cyc("raw_issue",  1'b0, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0010, 2'b01, 4'd0, 2'b00, 3'b000, 16'd3, 16'd0);
        cyc("raw_after",  1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd3, 16'd0);

        // LW, two NOPs, SW reading the loaded register via Rs2: 1 stall
        do_reset();
        cyc("lw",         1'b0, 8'h30, 5'd2, 5'd0, 5'd7, 4'b1010, 2'b00, 4'd0, 2'b01, 3'b000, 16'd0, 16'd0);
        cyc("lw_nop1",    1'b0, 8'h00, 5'd7, 5'd7, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("lw_nop2",    1'b0, 8'h00, 5'd7, 5'd7, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("sw_stall",   1'b0, 8'h31, 5'd3, 5'd7, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b100, 16'd0, 16'd0);
        cyc("sw_issue",   1'b0, 8'h31, 5'd3, 5'd7, 5'd0, 4'b0100, 2'b00, 4'd0, 2'b01, 3'b000, 16'd1, 16'd0);
        cyc("sw_after",   1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd1, 16'd0);

        // Jumps flush the following slot; then imm/shift/R decode and distance-2 RAW
        do_reset();
        cyc("jmp",        1'b0, 8'h40, 5'd1, 5'd2, 5'd3, 4'b0001, 2'b00, 4'd0, 2'b00, 3'b010, 16'd0, 16'd0);
        cyc("jmp_shadow", 1'b0, 8'h01, 5'd2, 5'd3, 5'd4, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd1);
        cyc("jmp_nop",    1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd1);
        cyc("jal",        1'b0, 8'h41, 5'd0, 5'd0, 5'd5, 4'b0011, 2'b10, 4'd0, 2'b00, 3'b010, 16'd0, 16'd1);
        cyc("jal_shadow", 1'b0, 8'h02, 5'd5, 5'd5, 5'd6, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd2);
        cyc("jal_nop",    1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd2);
        cyc("imm_0x13",   1'b0, 8'h13, 5'd9, 5'd0, 5'd10, 4'b0010, 2'b01, 4'd2, 2'b01, 3'b000, 16'd0, 16'd2);
        cyc("shift_0x28", 1'b0, 8'h28, 5'd11, 5'd0, 5'd12, 4'b0010, 2'b01, 4'd8, 2'b10, 3'b000, 16'd0, 16'd2);
        cyc("r_0x09",     1'b0, 8'h09, 5'd13, 5'd14, 5'd15, 4'b0010, 2'b01, 4'd8, 2'b00, 3'b000, 16'd0, 16'd2);
        cyc("imm_0x19",   1'b0, 8'h19, 5'd16, 5'd0, 5'd17, 4'b0010, 2'b01, 4'd8, 2'b01, 3'b000, 16'd0, 16'd2);
        cyc("d2_stall1",  1'b0, 8'h01, 5'd15, 5'd20, 5'd21, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b100, 16'd0, 16'd2);
        cyc("d2_stall2",  1'b0, 8'h01, 5'd15, 5'd20, 5'd21, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b100, 16'd1, 16'd2);
        cyc("d2_issue",   1'b0, 8'h01, 5'd15, 5'd20, 5'd21, 4'b0010, 2'b01, 4'd0, 2'b00, 3'b000, 16'd2, 16'd2);

        // Undefined opcode: bubble now, sticky Illegal from the next edge
        do_reset();
        cyc("ill_ff",     1'b0, 8'hFF, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("ill_add",    1'b0, 8'h01, 5'd2, 5'd3, 5'd4, 4'b0010, 2'b01, 4'd0, 2'b00, 3'b001, 16'd0, 16'd0);
        cyc("ill_lw",     1'b0, 8'h30, 5'd5, 5'd0, 5'd6, 4'b1010, 2'b00, 4'd0, 2'b01, 3'b001, 16'd0, 16'd0);
        cyc("ill_0x25",   1'b0, 8'h25, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b001, 16'd0, 16'd0);

        // Reset during the 2nd stall cycle, then the consumer issues cleanly
        do_reset();
        cyc("mr_prod",    1'b0, 8'h01, 5'd2, 5'd3, 5'd1, 4'b0010, 2'b01, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("mr_stall1",  1'b0, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b100, 16'd0, 16'd0);
        cyc("mr_rst",     1'b1, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("mr_release", 1'b0, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("mr_issue",   1'b0, 8'h01, 5'd1, 5'd5, 5'd4, 4'b0010, 2'b01, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);
        cyc("mr_after",   1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'd0, 16'd0);

        // Self-dependent ADD held in ID: 3 stalls per 4 cycles drives StallCount past 0xFFFF
        do_reset();
        @(posedge clk);
        #1;
        Op  = 8'h01;
        Rs1 = 5'd1;
        Rs2 = 5'd1;
        Rd  = 5'd1;
        repeat (87500) @(posedge clk);
        cyc("sat_nop1",   1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'hFFFF, 16'd0);
        cyc("sat_nop2",   1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 4'b0000, 2'b00, 4'd0, 2'b00, 3'b000, 16'hFFFF, 16'd0);

        @(negedge clk);
        #1;
        check_now("sat_final", {31'd0, 16'hFFFF} << 16);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
